connect_n_judge: RTL and testbench

- Parametrised successor to the game-termination checker for the Connect-N board.
- Generalised to any board size (COLS x ROWS) and win length N.
- Sequential scanner: on a start pulse it latches the board and the last-placed cell, walks outward from that cell one probe per cycle in 4 directions, and reports win, draw or no-result with a done pulse.
- Sits between the select logic, which produces grid and location, and the display.

---
 rtl/connect_n_judge.sv | 183 ++++++++++++++++++
 tb/tb_connect_n_judge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/connect_n_judge.sv
// connect_n_judge: sequential Connect-N termination checker.
// Latches the board and the last-placed cell, then probes outward from that
// cell one cell per cycle in four directions and reports win, draw or none.
module connect_n_judge #(
  parameter int unsigned COLS = 7,
  parameter int unsigned ROWS = 7,
  parameter int unsigned N    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [2*COLS*ROWS-1:0]         grid,
  input  logic [$clog2(COLS*ROWS)-1:0]   location,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     winner,
  output logic                           term
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned LOC_W = $clog2(CELLS);
  localparam int unsigned MAXD  = (COLS > ROWS) ? COLS : ROWS;
  localparam int unsigned CW    = $clog2(MAXD + 1) + 2;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;
  typedef logic signed [CW-1:0] coord_t;

  state_t                  state;
  logic [CELLS-1:0][1:0]   grid_q;
  logic [LOC_W-1:0]        loc_q;
  logic [1:0]              player;
  logic [1:0]              result;
  logic [1:0]              dir;
  logic                    neg;
  logic [CNT_W-1:0]        cnt;
  coord_t                  prow;
  coord_t                  pcol;

  coord_t                  loc_row_c;
  coord_t                  loc_col_c;
  logic                    loc_ok_c;
  logic [1:0]              loc_cell_c;
  logic                    in_bounds_c;
  logic [LOC_W-1:0]        probe_idx_c;
  logic [1:0]              probe_cell_c;
  logic                    hit_c;
  logic                    last_hit_c;
  logic                    top_full_c;

  // Row step for a direction; the negative half walks the mirrored way.
  function automatic coord_t step_row(input logic [1:0] d, input logic n);
    coord_t s;
    s = (d == 2'd0) ? coord_t'(0) : coord_t'(1);
    return n ? -s : s;
  endfunction

  // Column step: horizontal +1, vertical 0, diagonal +1, anti-diagonal -1.
  function automatic coord_t step_col(input logic [1:0] d, input logic n);
    coord_t s;
    case (d)
      2'd0:    s = coord_t'(1);
      2'd1:    s = coord_t'(0);
      2'd2:    s = coord_t'(1);
      default: s = coord_t'(-1);
    endcase
    return n ? -s : s;
  endfunction

  // Decode the latched location into row/col and fetch its cell.
  always_comb begin
    loc_ok_c   = (32'(loc_q) < CELLS);
    loc_row_c  = coord_t'(32'(loc_q) / COLS);
    loc_col_c  = coord_t'(32'(loc_q) % COLS);
    loc_cell_c = 2'b00;
    if (loc_ok_c) loc_cell_c = grid_q[loc_q];
  end

  // Bounds check on (row,col) so columns never wrap into the next row.
  always_comb begin
    in_bounds_c  = (int'(prow) >= 0) && (int'(prow) < int'(ROWS)) &&
                   (int'(pcol) >= 0) && (int'(pcol) < int'(COLS));
    probe_idx_c  = LOC_W'(int'(prow) * int'(COLS) + int'(pcol));
    probe_cell_c = 2'b00;
    if (in_bounds_c) probe_cell_c = grid_q[probe_idx_c];
    hit_c        = in_bounds_c && (probe_cell_c == player);
    last_hit_c   = (32'(cnt) + 32'd1) == (N - 1);
  end

  // Top row fully occupied (00 and 11 both count as empty).
  always_comb begin
    top_full_c = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      if (!(^grid_q[LOC_W'((ROWS - 1) * COLS + 32'(c))])) top_full_c = 1'b0;
    end
  end

  // Judge FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      grid_q <= '0;
      loc_q  <= '0;
      player <= 2'b00;
      result <= 2'b00;
      dir    <= 2'd0;
      neg    <= 1'b0;
      cnt    <= '0;
      prow   <= '0;
      pcol   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      winner <= 2'b00;
      term   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !term) begin
            grid_q <= grid;
            loc_q  <= location;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          player <= loc_cell_c;
          result <= 2'b00;
          dir    <= 2'd0;
          neg    <= 1'b0;
          cnt    <= '0;
          prow   <= loc_row_c + step_row(2'd0, 1'b0);
          pcol   <= loc_col_c + step_col(2'd0, 1'b0);
          if (!loc_ok_c || !(^loc_cell_c)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit_c) begin
            if (last_hit_c) begin
              result <= player;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              cnt  <= cnt + CNT_W'(1);
              prow <= prow + step_row(dir, neg);
              pcol <= pcol + step_col(dir, neg);
            end
          end else if (!neg) begin
            // Positive half ended: restart from the placed cell, keep the count.
            neg  <= 1'b1;
            prow <= loc_row_c + step_row(dir, 1'b1);
            pcol <= loc_col_c + step_col(dir, 1'b1);
          end else if (dir == 2'd3) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            dir  <= dir + 2'd1;
            neg  <= 1'b0;
            cnt  <= '0;
            prow <= loc_row_c + step_row(dir + 2'd1, 1'b0);
            pcol <= loc_col_c + step_col(dir + 2'd1, 1'b0);
          end
        end
        S_DONE: begin
          // A win outranks a draw; a full top row with no win is a draw.
          done   <= 1'b1;
          winner <= ((result == 2'b00) && top_full_c) ? 2'b11 : result;
          term   <= term | (result != 2'b00) | top_full_c;
          state  <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect_n_judge.sv
// tb_connect_n_judge: scoreboard bench for connect_n_judge (7x7, N=4).
module tb_connect_n_judge;

  localparam int CELLS = 49;
  localparam int GW    = 2 * CELLS;

  typedef struct {
    logic [1:0] win;
    int         lat;
    int         start_cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [GW-1:0] grid;
  logic [5:0]    location;
  logic          busy;
  logic          done;
  logic [1:0]    winner;
  logic          term;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   busy_cycles = 0;
  exp_t sb[$];
  exp_t e_mon;

  connect_n_judge #(.COLS(7), .ROWS(7), .N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .grid     (grid),
    .location (location),
    .busy     (busy),
    .done     (done),
    .winner   (winner),
    .term     (term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [GW-1:0] put(input logic [GW-1:0] g, input int idx,
                                         input logic [1:0] v);
    g[2*idx +: 2] = v;
    return g;
  endfunction

  // Full board without any 4-in-row: player by (col + 2*row) mod 4.
  function automatic logic [GW-1:0] draw_board();
    logic [GW-1:0] g;
    g = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        g = put(g, r*7 + c, (((c + 2*r) % 4) < 2) ? 2'b01 : 2'b10);
    return g;
  endfunction

  // Output monitor: pop the expected judgement on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("winner", winner, e_mon.win);
          check("term", term, (e_mon.win != 2'b00) ? 1 : 0);
          check("latency", cyc - e_mon.start_cyc, e_mon.lat);
          check("busy_cycles", busy_cycles, e_mon.lat - 1);
        end
        busy_cycles = 0;
      end
    end
  end

  task automatic run(input string name, input logic [GW-1:0] g, input logic [5:0] loc,
                     input logic [1:0] w, input int lat);
    exp_t e;
    bit   got;
    @(negedge clk);
    grid        = g;
    location    = loc;
    start       = 1'b1;
    e.win       = w;
    e.lat       = lat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    grid     = '1;
    location = 6'($urandom_range(0, 48));
    got      = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (sb.size() == 0) got = 1'b1;
    end
    if (!got) begin
      check({name, "_timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, "_busy"}, busy, 0);
    check({name, "_winner"}, winner, 0);
    check({name, "_term"}, term, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [GW-1:0] g_nowrap, g_hor, g_ver, g_diag, g_anti, g_inv;
    bit            saw;

    rst      = 1'b1;
    start    = 1'b0;
    grid     = '0;
    location = '0;

    g_nowrap = '0;
    g_nowrap = put(g_nowrap, 6, 2'b10);
    g_nowrap = put(g_nowrap, 7, 2'b10);
    g_nowrap = put(g_nowrap, 8, 2'b10);
    g_nowrap = put(g_nowrap, 9, 2'b10);

    g_hor = '0;
    for (int i = 0; i < 4; i++) g_hor = put(g_hor, i, 2'b01);

    g_ver = '0;
    for (int r = 0; r < 4; r++) g_ver = put(g_ver, r*7, 2'b10);

    g_diag = '0;
    for (int r = 0; r < 4; r++) g_diag = put(g_diag, r*7 + r, 2'b01);

    g_anti = '0;
    for (int r = 0; r < 4; r++) g_anti = put(g_anti, r*7 + (3 - r), 2'b10);

    g_inv = put(g_hor, 5, 2'b11);

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_winner", winner, 0);
    check("reset_term", term, 0);
    rst = 1'b0;

    // Row-0 col-6 must not connect to row-1 col-0: full 8-probe scan, no win.
    run("nowrap", g_nowrap, 6'd6, 2'b00, 10);
    run("loc49", g_nowrap, 6'd49, 2'b00, 2);
    run("loc_empty", g_nowrap, 6'd20, 2'b00, 2);
    run("loc_11", g_inv, 6'd5, 2'b00, 2);

    run("diag", g_diag, 6'd8, 2'b01, 10);
    do_reset("rst_a");
    run("anti", g_anti, 6'd15, 2'b10, 12);
    do_reset("rst_b");

    run("horiz", g_hor, 6'd3, 2'b01, 6);

    // Sticky term: a new start is ignored entirely.
    @(negedge clk);
    grid     = '0;
    location = '0;
    start    = 1'b1;
    @(negedge clk);
    saw   = busy | done;
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done) saw = 1'b1;
    end
    check("ignore_busy_done", saw, 0);
    check("ignore_winner", winner, 1);
    check("ignore_term", term, 1);
    do_reset("rst_c");

    // Reset three cycles into a vertical-win scan.
    @(negedge clk);
    grid     = g_ver;
    location = 6'd21;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_winner", winner, 0);
    check("mid_term", term, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run("vert", g_ver, 6'd21, 2'b10, 8);
    do_reset("rst_d");

    run("draw", draw_board(), 6'd45, 2'b11, 12);

    repeat (3) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
